// File: rtl/in_fm_tile_sched_pkg.sv
// Shared definitions for the input feature-map tile scheduler.
// Holds the scheduler FSM state type, a ceiling-divide helper and the tile
// counts derived from the default geometry (M=32, R=64, C=32, Tm=16, Tr=64, Tc=16).
package in_fm_tile_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_LOAD = 2'd2,
        DRAIN     = 2'd3
    } sched_state_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    localparam int unsigned DEF_M  = 32;
    localparam int unsigned DEF_R  = 64;
    localparam int unsigned DEF_C  = 32;
    localparam int unsigned DEF_TM = 16;
    localparam int unsigned DEF_TR = 64;
    localparam int unsigned DEF_TC = 16;

    localparam int unsigned TILES_M     = ceil_div(DEF_M, DEF_TM);
    localparam int unsigned TILES_R     = ceil_div(DEF_R, DEF_TR);
    localparam int unsigned TILES_C     = ceil_div(DEF_C, DEF_TC);
    localparam int unsigned TILES_TOTAL = TILES_M * TILES_R * TILES_C;

endpackage

// File: rtl/in_fm_tile_sched_stepper.sv
// Tile origin stepper: holds the (m, row, col) base registers of the tile
// currently being loaded and walks them col-innermost, then row, then m.
// Ports: clk/rst (async active-low), clear (zero all bases), advance (step to
// the next tile), base_m/base_row/base_col (current origin), is_last (the
// current origin is the final tile of the pass).
module in_fm_tile_stepper #(
    parameter int unsigned CW = 16,
    parameter int unsigned M  = 32,
    parameter int unsigned R  = 64,
    parameter int unsigned C  = 32,
    parameter int unsigned Tm = 16,
    parameter int unsigned Tr = 64,
    parameter int unsigned Tc = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] base_m,
    output logic [CW-1:0] base_row,
    output logic [CW-1:0] base_col,
    output logic          is_last
);

    localparam logic [CW-1:0] M_W  = CW'(M);
    localparam logic [CW-1:0] R_W  = CW'(R);
    localparam logic [CW-1:0] C_W  = CW'(C);
    localparam logic [CW-1:0] TM_W = CW'(Tm);
    localparam logic [CW-1:0] TR_W = CW'(Tr);
    localparam logic [CW-1:0] TC_W = CW'(Tc);

    logic [CW-1:0] m_inc, row_inc, col_inc;
    logic [CW-1:0] next_m, next_row, next_col;

    assign m_inc   = base_m   + TM_W;
    assign row_inc = base_row + TR_W;
    assign col_inc = base_col + TC_W;

    // Last tile: no dimension has room for another step.
    assign is_last = (m_inc >= M_W) && (row_inc >= R_W) && (col_inc >= C_W);

    always_comb begin
        next_m   = base_m;
        next_row = base_row;
        next_col = col_inc;
        if (col_inc >= C_W) begin
            next_col = '0;
            next_row = row_inc;
            if (row_inc >= R_W) begin
                next_row = '0;
                next_m   = m_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_m   <= '0;
            base_row <= '0;
            base_col <= '0;
        end else if (clear) begin
            base_m   <= '0;
            base_row <= '0;
            base_col <= '0;
        end else if (advance) begin
            base_m   <= next_m;
            base_row <= next_row;
            base_col <= next_col;
        end
    end

endmodule

// File: rtl/in_fm_tile_sched.sv
// Input feature-map tile scheduler with ping-pong buffering.
// Issues one tile load at a time into the free buffer, tracks which buffers
// hold loaded tiles, and presents the oldest loaded tile to the consumer.
// Ports: clk, rst (async active-low); start/busy/done pass control;
// load_start, load_base_*, load_buf_sel, load_done loader handshake;
// tile_valid, tile_buf_sel, tile_base_*, tile_last, tile_release consumer side.
module in_fm_tile_sched
    import in_fm_tile_sched_pkg::*;
#(
    parameter int unsigned CW = 16,
    parameter int unsigned M  = 32,
    parameter int unsigned R  = 64,
    parameter int unsigned C  = 32,
    parameter int unsigned Tm = 16,
    parameter int unsigned Tr = 64,
    parameter int unsigned Tc = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          load_start,
    output logic [CW-1:0] load_base_m,
    output logic [CW-1:0] load_base_row,
    output logic [CW-1:0] load_base_col,
    output logic          load_buf_sel,
    input  logic          load_done,
    output logic          tile_valid,
    output logic          tile_buf_sel,
    output logic [CW-1:0] tile_base_m,
    output logic [CW-1:0] tile_base_row,
    output logic [CW-1:0] tile_base_col,
    output logic          tile_last,
    input  logic          tile_release
);

    sched_state_t  state;
    logic          load_ptr, cons_ptr;
    logic [1:0]    full;
    logic [CW-1:0] slot_m   [2];
    logic [CW-1:0] slot_row [2];
    logic [CW-1:0] slot_col [2];
    logic [1:0]    slot_last;

    logic          step_last;
    logic [CW-1:0] cur_m, cur_row, cur_col;
    logic          rel_fire, ld_fire, load_slot_free;

    assign rel_fire = tile_release && full[cons_ptr];
    assign ld_fire  = (state == WAIT_LOAD) && load_done;
    // A release landing this cycle on the load target frees it in time to issue now.
    assign load_slot_free = !full[load_ptr] || (rel_fire && (cons_ptr == load_ptr));

    in_fm_tile_stepper #(
        .CW(CW), .M(M), .R(R), .C(C), .Tm(Tm), .Tr(Tr), .Tc(Tc)
    ) u_stepper (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state == IDLE) && start),
        .advance  (ld_fire),
        .base_m   (cur_m),
        .base_row (cur_row),
        .base_col (cur_col),
        .is_last  (step_last)
    );

    assign load_base_m   = cur_m;
    assign load_base_row = cur_row;
    assign load_base_col = cur_col;
    assign load_buf_sel  = load_ptr;

    assign tile_valid    = full[cons_ptr];
    assign tile_buf_sel  = cons_ptr;
    assign tile_base_m   = slot_m[cons_ptr];
    assign tile_base_row = slot_row[cons_ptr];
    assign tile_base_col = slot_col[cons_ptr];
    assign tile_last     = slot_last[cons_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_start <= 1'b0;
            load_ptr   <= 1'b0;
            cons_ptr   <= 1'b0;
            full       <= '0;
            slot_last  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                slot_m[i]   <= '0;
                slot_row[i] <= '0;
                slot_col[i] <= '0;
            end
        end else begin
            done       <= 1'b0;
            load_start <= 1'b0;

            // Release and load completion always address different buffers.
            if (rel_fire) begin
                full[cons_ptr] <= 1'b0;
                cons_ptr       <= ~cons_ptr;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        load_ptr <= 1'b0;
                        cons_ptr <= 1'b0;
                        full     <= '0;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (load_slot_free) begin
                        load_start <= 1'b1;
                        state      <= WAIT_LOAD;
                    end
                end
                WAIT_LOAD: begin
                    if (load_done) begin
                        full[load_ptr]      <= 1'b1;
                        slot_m[load_ptr]    <= cur_m;
                        slot_row[load_ptr]  <= cur_row;
                        slot_col[load_ptr]  <= cur_col;
                        slot_last[load_ptr] <= step_last;
                        load_ptr            <= ~load_ptr;
                        state               <= step_last ? DRAIN : ISSUE;
                    end
                end
                DRAIN: begin
                    if (full == 2'b00) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/in_fm_tile_sched.md
IN_FM_TILE_SCHED -- requirements
Module: in_fm_tile_sched

Interface
REQ-001 Parameters SHALL be: CW, default 16, counter/base width; M, default 32, input channels; R, default 64, rows; C, default 32, columns; Tm, default 16, channel tile; Tr, default 64, row tile; Tc, default 16, column tile.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that begins a full feature-map pass.
REQ-005 busy  output  1  high from accepted start until done.
REQ-006 done  output  1  one-cycle pulse when the pass completes.
REQ-007 load_start  output  1  one-cycle pulse requesting the loader to fetch one tile.
REQ-008 load_base_m / load_base_row / load_base_col  output  CW each  tile origin for the load; stable from load_start until load_done.
REQ-009 load_buf_sel  output  1  target ping-pong buffer for the load.
REQ-010 load_done  input  1  one-cycle pulse from the loader when the tile is fully written.
REQ-011 tile_valid  output  1  consumer buffer holds a loaded tile.
REQ-012 tile_buf_sel  output  1  buffer index the consumer reads.
REQ-013 tile_base_m / tile_base_row / tile_base_col  output  CW each  origin of the valid tile, driving the filter's base inputs.
REQ-014 tile_last  output  1  the valid tile is the final tile of the pass.
REQ-015 tile_release  input  1  one-cycle pulse when the consumer frees the valid tile.

Function
REQ-016 Tile order SHALL be col innermost (step Tc, while base < C), then row (step Tr, while base < R), then m (step Tm, while base < M). Partial edge tiles SHALL be issued.
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_LOAD and DRAIN.
REQ-018 IDLE: start SHALL clear the bases, the pointers and both full flags, set busy and enter ISSUE. start in any other state SHALL be ignored.
REQ-019 ISSUE: if the buffer at load_ptr is empty, the block SHALL pulse load_start with the current bases and load_buf_sel=load_ptr, then enter WAIT_LOAD. Otherwise it SHALL stall in ISSUE with no pulse.
REQ-020 The first load_start SHALL occur exactly one cycle after the edge that samples start.
REQ-021 WAIT_LOAD on load_done: the block SHALL set full[load_ptr], latch the bases and a last flag into that buffer's slot, toggle load_ptr and advance the bases. It SHALL then enter DRAIN if that tile was the last, else ISSUE.
REQ-022 load_done outside WAIT_LOAD SHALL be ignored.
REQ-023 DRAIN: when both full flags are clear, the block SHALL pulse done for one cycle, clear busy and enter IDLE.
REQ-024 Consumer side: tile_valid=full[cons_ptr], tile_buf_sel=cons_ptr, and tile_base_* and tile_last SHALL come from the cons_ptr slot.
REQ-025 tile_valid SHALL rise the cycle after load_done.
REQ-026 tile_release while tile_valid SHALL clear full[cons_ptr] and toggle cons_ptr. tile_release while !tile_valid SHALL be ignored.
REQ-027 Simultaneous load_done and tile_release SHALL both take effect in the same cycle. They never target the same buffer.
REQ-028 Base arithmetic SHALL be CW-bit. Comparisons against M/R/C SHALL use the post-increment value without overflow for the parameter ranges used.

Reset
REQ-029 While rst=0, the block SHALL hold state=IDLE, every output at 0, all bases 0, both pointers 0 and both full flags 0, including mid-pass. No done pulse SHALL be emitted.

Structure
REQ-030 The FSM state encoding and the derived localparams SHALL live in the shared package/header. Derived localparams: tiles per dimension = ceil(M/Tm), ceil(R/Tr), ceil(C/Tc), and their product.
REQ-031 A single sub-module, in_fm_tile_stepper, SHALL hold the three base registers and produce the next bases and the last indication.

Verification
REQ-032 Defaults, loader answering load_done 3 cycles after load_start, consumer releasing 2 cycles after tile_valid -> 4 tiles with bases (0,0,0),(0,0,16),(16,0,0),(16,0,16), buffers 0,1,0,1, tile_last on the 4th tile only, one done pulse.
REQ-033 C=40 -> column bases 0,16,32 per m tile, 6 tiles in total.
REQ-034 Consumer never releases -> exactly 2 load_start pulses, then the block stalls in ISSUE with busy=1. One release -> a 3rd load_start on the next cycle.
REQ-035 load_done and tile_release in the same cycle -> the new buffer goes full, the other buffer is freed, and tile_valid remains 1 at the new cons_ptr.
REQ-036 rst driven low mid-WAIT_LOAD -> all outputs 0 immediately. Then after a new start -> the pass restarts at (0,0,0).
REQ-037 start pulsed while busy, and load_done pulsed in IDLE -> no effect on state or outputs.
